// File: rtl/fib_sequencer.sv
// Fibonacci-style sequence engine: start/ready/done handshake controller plus A/B/C datapath.
// Streams every term T(0)..T(n), tracks wrap-around overflow and supports abort.
module fib_sequencer #(
    parameter int WIDTH = 16,
    parameter int NW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [NW-1:0]    n,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             term_valid,
    output logic [WIDTH-1:0] term
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SUM   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] a_q,        a_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic [WIDTH-1:0] s_q,        s_d;
    logic [NW-1:0]    c_q,        c_d;
    logic             ovf_acc_q,  ovf_acc_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH:0]   sum_full;

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        c_d        = c_q;
        ovf_acc_d  = ovf_acc_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = seed_a;
                    b_d       = seed_b;
                    c_d       = n;
                    ovf_acc_d = 1'b0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (c_q == '0) begin
                    result_d   = a_q;
                    overflow_d = ovf_acc_q;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    s_d = sum_full[WIDTH-1:0];
                    // With C==1 the sum is T(n+1), which is never reported, so its carry is ignored.
                    if (sum_full[WIDTH] && (c_q > NW'(1))) begin
                        ovf_acc_d = 1'b1;
                    end
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    a_d     = b_q;
                    b_d     = s_q;
                    c_d     = c_q - NW'(1);
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            c_q        <= '0;
            ovf_acc_q  <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s_q        <= s_d;
            c_q        <= c_d;
            ovf_acc_q  <= ovf_acc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign done       = (state_q == S_DONE);
    assign term_valid = (state_q == S_CHECK);
    assign term       = a_q;
    assign result     = result_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Randomised self-checking bench for fib_sequencer against a plain-arithmetic sequence model.
// Edge counts below include the edge that samples start as edge 1.
module tb_fib_sequencer;

    localparam int W  = 16;
    localparam int NW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NW-1:0] n;
    logic [W-1:0]  seed_a;
    logic [W-1:0]  seed_b;
    logic          ready;
    logic          done;
    logic [W-1:0]  result;
    logic          overflow;
    logic          term_valid;
    logic [W-1:0]  term;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] prev_res;
    logic         prev_ovf;
    logic [W-1:0] exp_terms[$];
    logic [W-1:0] exp_res;
    logic         exp_ovf;

    fib_sequencer #(.WIDTH(W), .NW(NW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .n          (n),
        .seed_a     (seed_a),
        .seed_b     (seed_b),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .term_valid (term_valid),
        .term       (term)
    );

    always #5 clock = ~clock;

    // Reference: full-precision sums, overflow if any reported term T(2..n) exceeds the width.
    task automatic model(input int rn, input logic [W-1:0] sa, input logic [W-1:0] sb);
        longint unsigned full;
        longint unsigned lim;
        lim = 64'd1 << W;
        exp_terms.delete();
        exp_ovf = 1'b0;
        exp_terms.push_back(sa);
        if (rn >= 1) exp_terms.push_back(sb);
        for (int k = 2; k <= rn; k++) begin
            full = 64'(exp_terms[k-1]) + 64'(exp_terms[k-2]);
            if (full >= lim) exp_ovf = 1'b1;
            exp_terms.push_back(full[W-1:0]);
        end
        exp_res = exp_terms[rn];
    endtask

    // One run: cut_at>0 applies abort (or reset) sampled at that edge count; busy_at>0 pulses a stray start.
    task automatic do_run(input string tag, input int rn, input logic [W-1:0] sa, input logic [W-1:0] sb,
                          input int cut_at, input bit cut_reset, input int busy_at);
        int edge_cnt;
        int tcount;
        int exp_tcount;
        bit seen_done;
        bit cut_seen;
        bit finished;
        int limit;
        model(rn, sa, sb);
        @(negedge clock);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_before_start: got %b expected 1", tag, ready);
        end
        start = 1'b1; n = NW'(rn); seed_a = sa; seed_b = sb;
        @(posedge clock);
        edge_cnt = 1; tcount = 0; seen_done = 0; cut_seen = 0; finished = 0;
        limit = 3 * rn + 12;
        for (int guard = 0; guard < limit && !finished; guard++) begin
            @(negedge clock);
            if (seen_done || cut_seen) begin
                vectors++;
                if (ready !== 1'b1 || done !== 1'b0 || result !== prev_res || overflow !== prev_ovf) begin
                    miscompares++;
                    $display("FAIL %s after_end: ready=%b done=%b result=%0d ovf=%b expected ready=1 done=0 result=%0d ovf=%b",
                             tag, ready, done, result, overflow, prev_res, prev_ovf);
                end
                finished = 1;
            end else begin
                if (term_valid === 1'b1) begin
                    vectors++;
                    if (tcount > rn || term !== exp_terms[tcount] || edge_cnt != 3 * tcount + 1) begin
                        miscompares++;
                        $display("FAIL %s term[%0d]: got %0d at edge %0d expected %0d at edge %0d",
                                 tag, tcount, term, edge_cnt, (tcount <= rn) ? exp_terms[tcount] : 0, 3 * tcount + 1);
                    end
                    tcount++;
                end
                if (done === 1'b1) begin
                    vectors++;
                    if (cut_at > 0 || edge_cnt != 3 * rn + 2 || result !== exp_res || overflow !== exp_ovf) begin
                        miscompares++;
                        $display("FAIL %s done: got edge %0d result %0d ovf %b expected edge %0d result %0d ovf %b",
                                 tag, edge_cnt, result, overflow, 3 * rn + 2, exp_res, exp_ovf);
                    end
                    seen_done = 1;
                    prev_res  = exp_res;
                    prev_ovf  = exp_ovf;
                end
            end
            start = 1'b0; abort = 1'b0; reset = 1'b0;
            n = NW'($urandom); seed_a = W'($urandom); seed_b = W'($urandom);
            if (!finished) begin
                if (edge_cnt + 1 == cut_at) begin
                    if (cut_reset) reset = 1'b1;
                    else abort = 1'b1;
                end
                if (edge_cnt + 1 == busy_at) begin
                    start = 1'b1;
                    n     = NW'(9);
                end
                @(posedge clock);
                edge_cnt++;
                if (edge_cnt == cut_at) begin
                    cut_seen = 1;
                    if (cut_reset) begin
                        prev_res = '0;
                        prev_ovf = 1'b0;
                    end
                end
            end
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL %s timeout: run did not end within %0d cycles", tag, limit);
        end
        exp_tcount = 0;
        for (int k = 0; k <= rn; k++) begin
            if (cut_at == 0 || 3 * k + 1 < cut_at) exp_tcount++;
        end
        vectors++;
        if (tcount != exp_tcount || seen_done != (cut_at == 0)) begin
            miscompares++;
            $display("FAIL %s pulse_count: got %0d terms done=%0b expected %0d terms done=%0b",
                     tag, tcount, seen_done, exp_tcount, (cut_at == 0));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; n = '0; seed_a = '0; seed_b = '0;
        @(posedge clock);
        @(negedge clock);
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || term_valid !== 1'b0 || result !== '0 || overflow !== 1'b0 || term !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b done=%b tv=%b result=%0d ovf=%b term=%0d expected 1 0 0 0 0 0",
                     ready, done, term_valid, result, overflow, term);
        end
        @(negedge clock);
        reset = 1'b0;
        prev_res = '0;
        prev_ovf = 1'b0;
    endtask

    task automatic test_basic();
        do_run("basic_n10", 10, 16'd0, 16'd1, 0, 1'b0, 0);
        do_run("n0", 0, 16'h1234, 16'hBEEF, 0, 1'b0, 0);
        do_run("n1", 1, 16'h00AA, 16'h0055, 0, 1'b0, 0);
    endtask

    task automatic test_overflow_boundary();
        do_run("ovf_n24", 24, 16'd0, 16'd1, 0, 1'b0, 0);
        do_run("ovf_n25", 25, 16'd0, 16'd1, 0, 1'b0, 0);
        do_run("ovf_max_seeds", 2, 16'hFFFF, 16'hFFFF, 0, 1'b0, 0);
    endtask

    task automatic test_abort();
        do_run("pre_abort", 10, 16'd0, 16'd1, 0, 1'b0, 0);
        do_run("abort_n20", 20, 16'd0, 16'd1, 11, 1'b0, 0);
        do_run("after_abort", 3, 16'd0, 16'd1, 0, 1'b0, 0);
        do_run("abort_last_check", 2, 16'd7, 16'd9, 8, 1'b0, 0);
    endtask

    task automatic test_busy();
        do_run("busy_n5", 5, 16'd0, 16'd1, 0, 1'b0, 4);
    endtask

    task automatic test_reset_midrun();
        do_run("reset_mid", 15, 16'd0, 16'd1, 7, 1'b1, 0);
        do_run("after_reset", 7, 16'd0, 16'd1, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        int rn;
        int cut;
        bit use_reset;
        for (int i = 0; i < 16; i++) begin
            rn  = $urandom_range(0, 40);
            cut = 0;
            use_reset = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                cut = $urandom_range(2, 3 * rn + 2);
                use_reset = ($urandom_range(0, 1) == 1);
            end
            do_run("random", rn, W'($urandom), W'($urandom), cut, use_reset, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow_boundary();
        test_abort();
        test_busy();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
